// File: rtl/crc32_pkg.sv
// Shared CRC-32/MPEG-2 definitions for the serial generator and checker:
// constants, the frame state encoding and the single-bit LFSR update.
package crc32_pkg;

  localparam int              CRC_W      = 32;
  localparam logic [CRC_W-1:0] POLY_CRC32 = 32'h04C11DB7;
  localparam logic [CRC_W-1:0] INIT_CRC32 = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } crc_state_e;

  // One MSB-first step of the unreflected CRC LFSR.
  function automatic logic [CRC_W-1:0] crc32_step(
    input logic [CRC_W-1:0] lfsr,
    input logic             din,
    input logic [CRC_W-1:0] poly = POLY_CRC32
  );
    logic fb;
    fb = lfsr[CRC_W-1] ^ din;
    return {lfsr[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
  endfunction

endpackage

// File: rtl/crc32_lfsr_ser.sv
// Serial CRC-32 LFSR register: init loads the seed, step absorbs one data
// bit, shift_out moves the accumulated CRC out MSB-first.
module crc32_lfsr_ser
  import crc32_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = POLY_CRC32,
  parameter logic [CRC_W-1:0] INIT = INIT_CRC32
) (
  input  logic clk,
  input  logic rst,
  input  logic init_i,
  input  logic step_i,
  input  logic shift_out_i,
  input  logic din_i,
  output logic msb_o
);

  logic [CRC_W-1:0] lfsr_q;
  logic [CRC_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (init_i) begin
      lfsr_d = INIT;
    end else if (step_i) begin
      lfsr_d = crc32_step(lfsr_q, din_i, POLY);
    end else if (shift_out_i) begin
      lfsr_d = {lfsr_q[CRC_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= INIT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign msb_o = lfsr_q[CRC_W-1];

endmodule

// File: rtl/crc_32_serial_chk.sv
// Serial CRC-32/MPEG-2 checker: data bits, then the 32 appended CRC bits.
// Define CRC_CHK_ERRCNT_EN to add the saturating failed-frame counter err_cnt.
module crc_32_serial_chk
  import crc32_pkg::*;
#(
  parameter int               CRC_W_P = CRC_W,
  parameter logic [CRC_W-1:0] POLY    = POLY_CRC32,
  parameter logic [CRC_W-1:0] INIT    = INIT_CRC32
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic bit_en,
  input  logic d_finish,
  input  logic crc_in,
  output logic busy,
  output logic done,
  output logic crc_ok,
  output logic crc_err
`ifdef CRC_CHK_ERRCNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  crc_state_e state_q;
  logic [5:0] cnt_q;
  logic       mism_q;
  logic       busy_q;
  logic       done_q;
  logic       ok_q;
  logic       err_q;

  logic lfsr_msb;
  logic lfsr_step;
  logic lfsr_shift;
  logic mism_d;
  logic last_bit;

  assign lfsr_step  = !load && (state_q == DATA) && !d_finish && bit_en;
  assign lfsr_shift = !load && (state_q == CHECK) && bit_en;
  assign mism_d     = mism_q | (crc_in ^ lfsr_msb);
  assign last_bit   = lfsr_shift && (cnt_q == 6'(CRC_W_P - 1));

  crc32_lfsr_ser #(
    .POLY (POLY),
    .INIT (INIT)
  ) u_lfsr (
    .clk         (clk),
    .rst         (rst),
    .init_i      (load),
    .step_i      (lfsr_step),
    .shift_out_i (lfsr_shift),
    .din_i       (crc_in),
    .msb_o       (lfsr_msb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mism_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (load) begin
      state_q <= DATA;
      cnt_q   <= '0;
      mism_q  <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        DATA: begin
          if (d_finish) begin
            state_q <= CHECK;
            cnt_q   <= '0;
          end
        end
        CHECK: begin
          if (bit_en) begin
            mism_q <= mism_d;
            cnt_q  <= cnt_q + 6'd1;
          end
          // Verdict is registered together with the entry into DONE so it
          // appears in the same cycle as the done pulse.
          if (last_bit) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ok_q    <= ~mism_d;
            err_q   <= mism_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CRC_CHK_ERRCNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q <= '0;
    end else if (last_bit && mism_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign busy    = busy_q;
  assign done    = done_q;
  assign crc_ok  = ok_q;
  assign crc_err = err_q;

endmodule

// File: doc/crc_32_serial_chk.md
Name: crc_32_serial_chk

Overview:
- Serial CRC-32 checker. It is the receive-side counterpart of the team's serial CRC-32 generator.
- It consumes a bit stream of data followed by the 32-bit CRC the generator appended, then reports pass or fail.
- It sits after the serial link deserialiser, ahead of frame accept/drop logic.
- CRC convention: CRC-32/MPEG-2.
  - polynomial 0x04C11DB7
  - init all-ones
  - MSB-first
  - no reflection, no final XOR

Parameters:
- CRC_W, 32, CRC width (fixed at 32; parameterised for the package constant only)
- POLY, 32'h04C11DB7, generator polynomial, normal form
- INIT, 32'hFFFFFFFF, LFSR value loaded on load

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- load  in  1  start-of-frame: initialise LFSR and enter DATA
- bit_en  in  1  crc_in valid this cycle (gaps allowed)
- d_finish  in  1  end of data bits; the following 32 valid bits are the received CRC
- crc_in  in  1  serial bit, MSB of each byte first
- busy  out  1  frame in progress (DATA or CHECK)
- done  out  1  one-cycle pulse when the check completes
- crc_ok  out  1  last frame passed; held until next load
- crc_err  out  1  last frame failed; held until next load

Behaviour:
- Reset (rst=0, async): state IDLE, lfsr=INIT, cnt=0, mism=0. busy, done, crc_ok and crc_err are all 0.
- States: IDLE, DATA, CHECK, DONE.
- load=1 in any state, highest priority:
  - lfsr<=INIT, cnt<=0, mism<=0
  - crc_ok<=0, crc_err<=0
  - state<=DATA
  - crc_in on the load cycle is ignored.
- DATA, d_finish=0, bit_en=1:
  - fb = lfsr[31]^crc_in
  - lfsr <= {lfsr[30:0],1'b0} ^ (fb ? POLY : 0)
- DATA, d_finish=1:
  - state<=CHECK, cnt<=0
  - crc_in on this cycle is not consumed, regardless of bit_en.
  - d_finish with zero data bits is legal; the expected CRC is then INIT.
- CHECK, bit_en=1:
  - mism <= mism | (crc_in ^ lfsr[31])
  - lfsr <= lfsr<<1
  - cnt <= cnt+1 (6-bit)
  - On the 32nd bit (cnt==31): state<=DONE. The final bit's mismatch is included in the verdict.
- DONE, one cycle:
  - done=1
  - crc_ok = ~mism_final
  - crc_err = mism_final
  - state<=IDLE
- Latency: done is asserted on the cycle after the clock edge that samples the 32nd CRC bit.
- IDLE:
  - bit_en, d_finish and crc_in are ignored.
  - crc_ok and crc_err hold their values.
- d_finish in CHECK, DONE or IDLE: ignored.
- bit_en=0 in DATA or CHECK: lfsr, cnt and mism hold.
- busy=1 in DATA and CHECK only.
- crc_ok and crc_err are never both 1.
- Reset mid-frame aborts immediately: all outputs go to 0 and no done pulse is issued.

Optional Feature:
- Macro: CRC_CHK_ERRCNT_EN
- Defined:
  - Adds output err_cnt [15:0]: a saturating count of frames ending with crc_err.
  - Increments in the DONE cycle; holds at 16'hFFFF.
  - Cleared only by rst; load does not affect it.
- Undefined: no port and no counter. All other behaviour is identical.

Decomposition:
- Package crc32_pkg holds:
  - CRC_W, POLY_CRC32, INIT_CRC32
  - the state enum (IDLE/DATA/CHECK/DONE)
  - function crc32_step(lfsr, bit), shared with the generator
- One sub-module is natural: crc32_lfsr_ser. It holds the LFSR register, with controls init, step and shift_out, and is reusable by the generator.
- The FSM, counter and mismatch flag live in the top level.

Test Plan:
- Pass case:
  - Stimulus: load; 72 bits of ASCII "123456789" (0x31..0x39, MSB-first, bit_en=1); d_finish; 32 bits of 0x0376E6E7.
  - Required: done pulse 1 cycle after the last bit; crc_ok=1, crc_err=0; busy=0 after done.
- Single-bit error: same frame with one data bit flipped (or CRC bit 0 flipped) -> crc_err=1, crc_ok=0. With CRC_CHK_ERRCNT_EN, err_cnt increments to 1.
- Empty frame: load; d_finish immediately; 32 ones (0xFFFFFFFF) -> crc_ok=1.
- bit_en gaps:
  - Stimulus: the "123456789" frame with bit_en deasserted on random cycles (including during CHECK).
  - Required: same result as the pass case; done timing follows the 32nd valid CRC bit.
- Abort and restart:
  - rst pulled low at data bit 40 -> all outputs 0, no done.
  - Separately, load asserted mid-CHECK -> the frame restarts; a fresh correct frame gives crc_ok=1.
- Sticky verdict: after a pass, 100 idle cycles toggling crc_in/d_finish -> crc_ok stays 1 and no extra done.
